// File: rtl/game_period_timer.sv
// Game-phase sequencer: walks each level through PRELIM/GAME/ANSWER/POST, counting 1 Hz ticks.
// All outputs registered; a Start or Tick1Hz sampled at edge N is visible after edge N.
module game_period_timer #(
    parameter int PRELIM_SEC = 3,
    parameter int GAME_SEC   = 30,
    parameter int ANSWER_SEC = 10,
    parameter int POST_SEC   = 5,
    parameter int MAX_LEVEL  = 9
) (
    input  logic       Clk100M,
    input  logic       ResetN,
    input  logic       Tick1Hz,
    input  logic       Start,
    input  logic       Pause,
    output logic       prelimPeriod,
    output logic       gamePeriod,
    output logic       answerPeriod,
    output logic       postPeriod,
    output logic [3:0] level,
    output logic [6:0] secondsLeft,
    output logic       periodChng,
    output logic       levelChng,
    output logic       done
);

    // One-hot encoding so each period flag is a flop output.
    localparam logic [4:0] S_IDLE   = 5'b00001;
    localparam logic [4:0] S_PRELIM = 5'b00010;
    localparam logic [4:0] S_GAME   = 5'b00100;
    localparam logic [4:0] S_ANSWER = 5'b01000;
    localparam logic [4:0] S_POST   = 5'b10000;

    localparam logic [6:0] PRELIM_LEN = 7'(PRELIM_SEC);
    localparam logic [6:0] GAME_LEN   = 7'(GAME_SEC);
    localparam logic [6:0] ANSWER_LEN = 7'(ANSWER_SEC);
    localparam logic [6:0] POST_LEN   = 7'(POST_SEC);
    localparam logic [3:0] LAST_LEVEL = 4'(MAX_LEVEL);

    logic [4:0] state_q, state_d;
    logic [3:0] level_q, level_d;
    logic [6:0] secs_q,  secs_d;
    logic       done_q,  done_d;
    logic       pchg_q,  pchg_d;
    logic       lchg_q,  lchg_d;
    logic       adv;

    assign adv = Tick1Hz & ~Pause;

    always_ff @(posedge Clk100M) begin
        if (!ResetN) begin
            state_q <= S_IDLE;
            level_q <= 4'd0;
            secs_q  <= 7'd0;
            done_q  <= 1'b0;
            pchg_q  <= 1'b0;
            lchg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            secs_q  <= secs_d;
            done_q  <= done_d;
            pchg_q  <= pchg_d;
            lchg_q  <= lchg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        secs_d  = secs_q;
        done_d  = done_q;
        pchg_d  = 1'b0;
        lchg_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A tick coinciding with Start is deliberately not applied.
                if (Start) begin
                    state_d = S_PRELIM;
                    level_d = 4'd1;
                    secs_d  = PRELIM_LEN;
                    pchg_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_PRELIM, S_GAME, S_ANSWER, S_POST: begin
                if (adv) begin
                    if (secs_q > 7'd1) begin
                        secs_d = secs_q - 7'd1;
                    end else begin
                        pchg_d = 1'b1;
                        case (state_q)
                            S_PRELIM: begin
                                state_d = S_GAME;
                                secs_d  = GAME_LEN;
                            end
                            S_GAME: begin
                                state_d = S_ANSWER;
                                secs_d  = ANSWER_LEN;
                            end
                            S_ANSWER: begin
                                state_d = S_POST;
                                secs_d  = POST_LEN;
                            end
                            default: begin
                                if (level_q < LAST_LEVEL) begin
                                    state_d = S_PRELIM;
                                    level_d = level_q + 4'd1;
                                    secs_d  = PRELIM_LEN;
                                    lchg_d  = 1'b1;
                                end else begin
                                    state_d = S_IDLE;
                                    level_d = 4'd0;
                                    secs_d  = 7'd0;
                                    done_d  = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                level_d = 4'd0;
                secs_d  = 7'd0;
            end
        endcase
    end

    always_comb begin
        prelimPeriod = state_q[1];
        gamePeriod   = state_q[2];
        answerPeriod = state_q[3];
        postPeriod   = state_q[4];
        level        = level_q;
        secondsLeft  = secs_q;
        periodChng   = pchg_q;
        levelChng    = lchg_q;
        done         = done_q;
    end

endmodule

// File: tb/tb_game_period_timer.sv
// Bench for game_period_timer: two instances (one level / three levels) share directed stimulus.
module tb_game_period_timer;

    localparam int P = 2, G = 3, A = 2, Q = 1;
    localparam int CYC = P + G + A + Q;

    int maxl [2] = '{1, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, tick = 1'b0, start = 1'b0, pause = 1'b0;
    logic [1:0] pre, gam, ans, pst, pc, lc, dn;
    logic [3:0] lv [2];
    logic [6:0] sl [2];

    game_period_timer #(.PRELIM_SEC(P), .GAME_SEC(G), .ANSWER_SEC(A), .POST_SEC(Q), .MAX_LEVEL(1)) u_one (
        .Clk100M(clk), .ResetN(rst_n), .Tick1Hz(tick), .Start(start), .Pause(pause),
        .prelimPeriod(pre[0]), .gamePeriod(gam[0]), .answerPeriod(ans[0]), .postPeriod(pst[0]),
        .level(lv[0]), .secondsLeft(sl[0]), .periodChng(pc[0]), .levelChng(lc[0]), .done(dn[0]));

    game_period_timer #(.PRELIM_SEC(P), .GAME_SEC(G), .ANSWER_SEC(A), .POST_SEC(Q), .MAX_LEVEL(3)) u_three (
        .Clk100M(clk), .ResetN(rst_n), .Tick1Hz(tick), .Start(start), .Pause(pause),
        .prelimPeriod(pre[1]), .gamePeriod(gam[1]), .answerPeriod(ans[1]), .postPeriod(pst[1]),
        .level(lv[1]), .secondsLeft(sl[1]), .periodChng(pc[1]), .levelChng(lc[1]), .done(dn[1]));

    // Model: a run is just the number of accepted ticks since Start; everything else is arithmetic on it.
    bit run [2];
    int t [2];
    bit m_done [2], m_pc [2], m_lc [2];

    int n_cmp = 0, n_bad = 0;
    int pc_cnt [2], lc_cnt [2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void expect_of(input int k, output int per, output int lvl, output int secs);
        int r;
        per = 0; lvl = 0; secs = 0;
        if (run[k]) begin
            r   = t[k] % CYC;
            lvl = t[k] / CYC + 1;
            if (r < P)              begin per = 1; secs = P - r; end
            else if (r < P + G)     begin per = 2; secs = P + G - r; end
            else if (r < P + G + A) begin per = 3; secs = P + G + A - r; end
            else                    begin per = 4; secs = CYC - r; end
        end
    endfunction

    task automatic model_step();
        int r;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 1'b0;
            m_lc[k] = 1'b0;
            if (!rst_n) begin
                run[k] = 1'b0; t[k] = 0; m_done[k] = 1'b0;
            end else if (!run[k]) begin
                if (start) begin
                    run[k] = 1'b1; t[k] = 0; m_done[k] = 1'b0; m_pc[k] = 1'b1;
                end
            end else if (tick && !pause) begin
                t[k]++;
                if (t[k] == maxl[k] * CYC) begin
                    run[k] = 1'b0; m_done[k] = 1'b1; m_pc[k] = 1'b1;
                end else begin
                    r = t[k] % CYC;
                    if (r == 0 || r == P || r == P + G || r == P + G + A) m_pc[k] = 1'b1;
                    if (r == 0) m_lc[k] = 1'b1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        int per, lvl, secs;
        for (int k = 0; k < 2; k++) begin
            expect_of(k, per, lvl, secs);
            check($sformatf("u%0d.prelimPeriod", k), pre[k], per == 1);
            check($sformatf("u%0d.gamePeriod", k),   gam[k], per == 2);
            check($sformatf("u%0d.answerPeriod", k), ans[k], per == 3);
            check($sformatf("u%0d.postPeriod", k),   pst[k], per == 4);
            check($sformatf("u%0d.level", k),        lv[k],  lvl);
            check($sformatf("u%0d.secondsLeft", k),  sl[k],  secs);
            check($sformatf("u%0d.periodChng", k),   pc[k],  m_pc[k]);
            check($sformatf("u%0d.levelChng", k),    lc[k],  m_lc[k]);
            check($sformatf("u%0d.done", k),         dn[k],  m_done[k]);
        end
    end

    task automatic cyc(input bit r, input bit tk, input bit st, input bit ps);
        rst_n = r; tick = tk; start = st; pause = ps;
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            pc_cnt[k] += int'(pc[k]);
            lc_cnt[k] += int'(lc[k]);
        end
    endtask

    initial begin
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        repeat (5) cyc(1, 1, 0, 0);
        check("idle_level", lv[1], 0);
        check("idle_secs", sl[1], 0);
        check("idle_flags", {pre, gam, ans, pst, dn}, 0);

        pc_cnt = '{0, 0};
        lc_cnt = '{0, 0};
        cyc(1, 0, 1, 0);
        check("start_prelim", pre[0], 1);
        check("start_secs", sl[0], 2);
        check("start_level", lv[0], 1);

        for (int i = 1; i <= 24; i++) begin
            cyc(1, 1, 0, 0);
            if (i == 2) begin
                check("t2_game", gam[1], 1);
                check("t2_secs", sl[1], 3);
            end
            if (i == 5) check("t5_answer", ans[1], 1);
            if (i == 7) check("t7_post", pst[1], 1);
            if (i == 8) begin
                check("one_done", dn[0], 1);
                check("one_pc_count", pc_cnt[0], 5);
                check("one_lc_count", lc_cnt[0], 0);
                check("t8_level", lv[1], 2);
                check("t8_levelChng", lc[1], 1);
            end
            if (i == 16) begin
                check("t16_level", lv[1], 3);
                check("t16_levelChng", lc[1], 1);
            end
            if (i == 24) begin
                check("t24_done", dn[1], 1);
                check("t24_level", lv[1], 0);
                check("three_lc_count", lc_cnt[1], 2);
                check("three_pc_count", pc_cnt[1], 13);
            end
        end
        cyc(1, 0, 0, 0);

        cyc(1, 1, 1, 0);
        check("start_tick_secs", sl[1], 2);
        check("start_clears_done", dn[0], 0);

        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        check("pre_pause_game", gam[1], 1);
        check("pre_pause_secs", sl[1], 3);
        repeat (4) cyc(1, 1, 0, 1);
        check("paused_secs", sl[1], 3);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        check("resumed_secs", sl[1], 2);

        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 0);
        check("start_in_answer_flag", ans[1], 1);
        check("start_in_answer_secs", sl[1], 2);
        check("start_in_answer_pc", pc[1], 0);

        repeat (8) cyc(1, 1, 0, 0);
        check("l2_answer", ans[1], 1);
        check("l2_level", lv[1], 2);
        cyc(0, 0, 0, 0);
        check("rst_outputs", {pre, gam, ans, pst, pc, lc, dn}, 0);
        check("rst_level", lv[1], 0);
        check("rst_secs", sl[1], 0);
        cyc(1, 0, 1, 0);
        check("restart_level", lv[1], 1);
        check("restart_prelim", pre[1], 1);
        repeat (3) cyc(1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
